// File: rtl/normalize.sv
// Floating-point post-add normalizer.
// Takes the raw magnitude of an adder result and normalizes it one bit per cycle.
// Carry overflow is handled with a single right shift.
// Rounding is round-to-nearest-even using a single guard bit.
// The packed {sign, exponent, fraction} word is presented through a valid/ready handshake.
module normalize #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       sign_res,
    input  logic [E_WIDTH-1:0]         exp_res,
    input  logic [M_WIDTH+1:0]         sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [E_WIDTH+M_WIDTH:0]   result
);

    localparam int R_WIDTH = E_WIDTH + M_WIDTH + 1;

    // Largest biased exponent, zero-extended into the widened exponent register.
    localparam logic [E_WIDTH:0] EXP_MAX = {1'b0, {E_WIDTH{1'b1}}};
    localparam logic [E_WIDTH:0] EXP_ONE = (E_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic                   sign_q,      sign_d;
    logic [E_WIDTH:0]       exp_q,       exp_d;
    logic [M_WIDTH+1:0]     sum_q,       sum_d;
    logic                   guard_q,     guard_d;
    logic                   out_valid_q, out_valid_d;
    logic [R_WIDTH-1:0]     result_q,    result_d;

    // Signed infinity: exponent all ones, fraction zero.
    function automatic logic [R_WIDTH-1:0] pack_inf(input logic s);
        pack_inf = {s, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    endfunction

    // Round-to-nearest-even on {hidden, fraction} using one guard bit.
    // A rounding carry-out bumps the exponent.
    // Any exponent that reaches all ones saturates to infinity.
    function automatic logic [R_WIDTH-1:0] round_pack(
        input logic               s,
        input logic [E_WIDTH:0]   e,
        input logic [M_WIDTH:0]   mant,
        input logic               g
    );
        logic [M_WIDTH+1:0] inc;
        logic [E_WIDTH+1:0] e_fin;
        logic [M_WIDTH-1:0] frac;
        inc   = {1'b0, mant};
        if (g && mant[0]) begin
            inc = inc + (M_WIDTH+2)'(1);
        end
        e_fin = {1'b0, e};
        frac  = inc[M_WIDTH-1:0];
        if (inc[M_WIDTH+1]) begin
            frac  = '0;
            e_fin = e_fin + (E_WIDTH+2)'(1);
        end
        if (e_fin >= {2'b00, {E_WIDTH{1'b1}}}) begin
            round_pack = pack_inf(s);
        end else begin
            round_pack = {s, e_fin[E_WIDTH-1:0], frac};
        end
    endfunction

    // Accept only while out of reset and idle.
    // Reset therefore also drops readiness immediately.
    assign in_ready  = rst && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Next-state and datapath decisions for every state.
    // Each branch either moves one step or parks in HOLD.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        sum_d       = sum_q;
        guard_d     = guard_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = sign_res;
                    exp_d   = {1'b0, exp_res};
                    sum_d   = sum;
                    guard_d = 1'b0;
                    state_d = NORM;
                end
            end

            NORM: begin
                if (exp_q == EXP_MAX) begin
                    // Operand was already infinite or NaN-class: pass infinity through.
                    result_d    = pack_inf(sign_q);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (sum_q == '0) begin
                    // Exact cancellation always gives positive zero.
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (sum_q[M_WIDTH+1]) begin
                    // Carry out of the adder: one right shift.
                    // The dropped bit is kept for rounding.
                    sum_d   = sum_q >> 1;
                    guard_d = sum_q[0];
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (sum_q[M_WIDTH]) begin
                    state_d = ROUND;
                end else if (exp_q == EXP_ONE) begin
                    // No room left to shift: flush to positive zero.
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EXP_ONE;
                end
            end

            ROUND: begin
                result_d    = round_pack(sign_q, exp_q, sum_q[M_WIDTH:0], guard_q);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    // The asynchronous reset clears every register, including the held result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sum_q       <= '0;
            guard_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sum_q       <= sum_d;
            guard_q     <= guard_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_normalize.sv
// Directed bench for normalize.
// A behavioural model predicts the outputs: result value from the arithmetic
// rules, plus the cycle at which the result appears.
// A compare process checks out_valid, in_ready and result on every falling edge.
// Each operation also checks its result and latency against hand-computed literals.
module tb_normalize;

    localparam int E  = 8;
    localparam int M  = 23;
    localparam int RW = E + M + 1;
    localparam int EMAX = (1 << E) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sign_res = 1'b0;
    logic [E-1:0]      exp_res = '0;
    logic [M+1:0]      sum = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [RW-1:0]     result;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit            m_busy = 1'b0;
    bit            m_valid = 1'b0;
    int            m_cnt = 0;
    logic [RW-1:0] m_result = '0;
    logic [RW-1:0] m_pend = '0;

    normalize #(.E_WIDTH(E), .M_WIDTH(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_res  (sign_res),
        .exp_res   (exp_res),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Value-level model: leading-one position decides the path.
    // Latency counts the edges from accept to a valid result.
    function automatic void model_calc(input logic s, input int e, input longint m,
                                       output logic [RW-1:0] res, output int lat);
        longint mant;
        int     ex;
        int     g;
        int     p;
        int     k;
        logic   done;
        res  = '0;
        lat  = 1;
        done = 1'b0;
        mant = 0;
        ex   = e;
        g    = 0;
        p    = 0;
        if (e == EMAX) begin
            res  = {s, {E{1'b1}}, {M{1'b0}}};
            lat  = 1;
            done = 1'b1;
        end else if (m == 0) begin
            res  = '0;
            lat  = 1;
            done = 1'b1;
        end else begin
            for (int i = 0; i <= M + 1; i++) if (m[i]) p = i;
            if (p == M + 1) begin
                g = int'(m & 1); mant = m >> 1; ex = e + 1; lat = 2;
            end else if (p == M) begin
                mant = m; lat = 2;
            end else begin
                k = M - p;
                if (e <= k) begin
                    res = '0; lat = e; done = 1'b1;
                end else begin
                    mant = m << k; ex = e - k; lat = 2 + k;
                end
            end
        end
        if (!done) begin
            if (g == 1 && (mant % 2) == 1) mant = mant + 1;
            if (mant == (longint'(1) << (M + 1))) begin
                mant = longint'(1) << M;
                ex   = ex + 1;
            end
            if (ex >= EMAX) res = {s, {E{1'b1}}, {M{1'b0}}};
            else            res = {s, ex[E-1:0], mant[M-1:0]};
        end
    endfunction

    // Model timeline: accept, count down the latency, then hold until out_ready.
    initial begin
        logic [RW-1:0] r;
        int            l;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_result = '0;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0; m_busy = 1'b0;
                end
            end else if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_valid = 1'b1; m_result = m_pend;
                end
            end else if (in_valid) begin
                model_calc(sign_res, int'(exp_res), longint'(sum), r, l);
                m_pend = r; m_cnt = l; m_busy = 1'b1;
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cyc out_valid", out_valid, m_valid);
            check("cyc in_ready", in_ready, rst && !m_busy);
            check("cyc result", result, m_result);
        end
    end

    // One operation: present, accept, wait bounded, check literals, back-pressure, release.
    task automatic do_op(input string name, input logic s, input logic [E-1:0] e,
                         input logic [M+1:0] m, input logic [RW-1:0] res_lit,
                         input int lat_lit, input int hold);
        int n;
        bit got;
        sign_res = s; exp_res = e; sum = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0; n = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (out_valid === 1'b1) got = 1'b1;
        end
        check({name, " out_valid seen"}, got, 1);
        check({name, " latency"}, n, lat_lit);
        check({name, " result"}, result, res_lit);
        check({name, " model"}, m_result, res_lit);
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; sign_res = ~s; exp_res = 8'h10; sum = 25'h1234;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check({name, " held result"}, result, res_lit);
            check({name, " held in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " released out_valid"}, out_valid, 0);
        check({name, " released in_ready"}, in_ready, 1);
        check({name, " result kept"}, result, res_lit);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset in_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 1);
        @(posedge clk); #1;

        do_op("normalized",   1'b0, 8'd127, 25'h0800000, 32'h3F800000, 2, 5);
        do_op("carry tie up", 1'b0, 8'd127, 25'h1000003, 32'h40000002, 2, 0);
        do_op("tie even",     1'b0, 8'd127, 25'h1000001, 32'h40000000, 2, 0);
        do_op("left shift",   1'b0, 8'd127, 25'h0200000, 32'h3E800000, 4, 0);
        do_op("zero",         1'b1, 8'd127, 25'h0000000, 32'h00000000, 1, 1);
        do_op("overflow",     1'b0, 8'd254, 25'h1000000, 32'h7F800000, 2, 0);
        do_op("underflow",    1'b0, 8'd1,   25'h0400000, 32'h00000000, 1, 0);
        do_op("exp all ones", 1'b1, 8'd255, 25'h0800000, 32'hFF800000, 1, 0);
        do_op("round carry",  1'b0, 8'd127, 25'h1FFFFFF, 32'h40800000, 2, 0);
        do_op("round to inf", 1'b0, 8'd253, 25'h1FFFFFF, 32'h7F800000, 2, 0);
        do_op("negative",     1'b1, 8'd100, 25'h1800000, 32'hB2C00000, 2, 0);
        do_op("late undflow", 1'b1, 8'd3,   25'h0000100, 32'h00000000, 3, 2);

        // reset in the middle of a long normalization
        sign_res = 1'b0; exp_res = 8'd127; sum = 25'h0000001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset result", result, 0);
        check("midreset in_ready", in_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("release in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("no stale out_valid", seen, 0);

        do_op("after reset",  1'b0, 8'd127, 25'h0800000, 32'h3F800000, 2, 0);
        do_op("deep shift",   1'b0, 8'd127, 25'h0000001, 32'h34000000, 25, 0);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/normalize.md
NORMALIZE -- requirements
Module: normalize

Interface
REQ-001 Parameter E_WIDTH, default 8, exponent field width.
REQ-002 Parameter M_WIDTH, default 23, stored fraction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream holds a valid sum.
REQ-006 in_ready  output  1  block can accept; equals (rst high AND state IDLE).
REQ-007 sign_res  input  1  sign of the raw sum.
REQ-008 exp_res  input  E_WIDTH  biased exponent of the larger operand.
REQ-009 sum  input  M_WIDTH+2  raw magnitude: bit M_WIDTH+1 is carry, bit M_WIDTH is hidden one, lower bits are fraction.
REQ-010 out_valid  output  1  result is valid; high only in HOLD.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  E_WIDTH+M_WIDTH+1  packed {sign, exponent, fraction}.

Function
REQ-013 Handshake: accept on a rising edge with in_valid=1 and in_ready=1. Capture sign, exponent into an E_WIDTH+1-bit register, sum, guard=0. Go to NORM.
REQ-014 States are IDLE, NORM, ROUND, HOLD, and each transition takes one clock.
REQ-015 NORM priority 1, captured exponent all-ones: result={sign, all-ones, zero}; go to HOLD.
REQ-016 NORM priority 2, sum==0: result is +0 (all zero, sign forced 0); go to HOLD.
REQ-017 NORM priority 3, carry bit set: shift sum right 1, guard=shifted-out bit, exponent+1; go to ROUND.
REQ-018 NORM priority 4, hidden bit set: go to ROUND unchanged.
REQ-019 NORM priority 5, exponent==1: underflow; result is +0; go to HOLD.
REQ-020 NORM otherwise: shift sum left 1, exponent-1, stay in NORM (one bit per cycle).
REQ-021 ROUND rounds to nearest, ties to even: if guard=1 and fraction LSB=1, increment {hidden, fraction}.
REQ-022 If the increment carries out, fraction becomes 0 and exponent is incremented.
REQ-023 ROUND: if the final exponent is all-ones or greater, result={sign, all-ones, zero} (infinity). Otherwise result={sign, exponent[E_WIDTH-1:0], fraction}. Go to HOLD.
REQ-024 HOLD: out_valid=1 and result stable until out_ready=1 on an edge, then go to IDLE. out_valid falls the following cycle, with no back-to-back output.
REQ-025 Latency from accept edge to out_valid high:
- 1 cycle for zero, exponent all-ones, or underflow detected at the first NORM cycle;
- 2 cycles for carry or already-normalized;
- 2+k cycles for k left shifts.
REQ-026 in_valid while not IDLE is ignored; no input is lost because in_ready is low.
REQ-027 result is held at its last value outside HOLD.

Reset
REQ-028 rst low asynchronously forces: state IDLE, out_valid 0, result 0, in_ready 0, and all internal registers 0.
REQ-029 Reset mid-operation discards the operation in flight, and no out_valid follows.
REQ-030 After rst rises, in_ready=1 from the first edge onward.

Verification
REQ-031 Normalized input: exp_res=127, sum=0x0800000, sign 0 -> result 0x3F800000, out_valid 2 cycles after accept.
REQ-032 Carry with tie round-up: exp_res=127, sum=0x1000003 -> result 0x40000002, latency 2.
REQ-033 Left shift and zero: exp_res=127, sum=0x0200000 -> result 0x3E800000, latency 4. sum=0, sign 1 -> result 0x00000000, latency 1.
REQ-034 Range limits: exp_res=254, sum=0x1000000 -> result 0x7F800000. exp_res=1, sum=0x0400000 -> result 0x00000000.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles -> out_valid and result stable and in_ready 0 throughout; one out_ready pulse -> IDLE next cycle.
REQ-036 Reset mid-operation: rst low during NORM of sum=0x0000001 -> outputs zero immediately; no out_valid after release; next operation is correct.
